dmem_responder: RTL and testbench

Responder end of the per-core data-cache memory interface. Accepts read and write requests from `NUM_CONSUMERS` data caches, arbitrates them round-robin onto one external data-memory port, and returns read data or write completion using the level-held valid/ready handshake the caches expect. It sits between the cores' data caches and the device data memory.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: state encoding and index-width helper shared by the data-memory responder
package dmem_pkg;
   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      READ_WAITING   = 3'd1,
      WRITE_WAITING  = 3'd2,
      READ_RELAYING  = 3'd3,
      WRITE_RELAYING = 3'd4
   } state_t;
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
   import dmem_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_bits(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          grant_valid
);
   logic [N-1:0] rot;
   always_comb begin
      rot = N'({req, req} >> ptr);
      grant = '0;
      grant_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            grant = IW'((int'(ptr) + k) % N);
            grant_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: round-robin funnel of per-core data-cache requests onto one data-memory port
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic                               mem_read_valid,
   output logic [ADDR_BITS-1:0]               mem_read_address,
   input  logic                               mem_read_ready,
   input  logic [DATA_BITS-1:0]               mem_read_data,
   output logic                               mem_write_valid,
   output logic [ADDR_BITS-1:0]               mem_write_address,
   output logic [DATA_BITS-1:0]               mem_write_data,
   input  logic                               mem_write_ready
);
   localparam int N  = NUM_CONSUMERS;
   localparam int IW = idx_bits(N);

   state_t                 state_q, state_d;
   logic [IW-1:0]          ch_q, ch_d, rr_q, rr_d, grant;
   logic                   grant_valid;
   logic                   mem_read_valid_q, mem_read_valid_d;
   logic                   mem_write_valid_q, mem_write_valid_d;
   logic [ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
   logic [ADDR_BITS-1:0]   mem_write_address_q, mem_write_address_d;
   logic [DATA_BITS-1:0]   mem_write_data_q, mem_write_data_d;
   logic [N-1:0]           read_ready_q, read_ready_d;
   logic [N-1:0]           write_ready_q, write_ready_d;
   logic [N*DATA_BITS-1:0] read_data_q, read_data_d;

   rr_arbiter #(.N(N), .IW(IW)) u_arb (
      .req         (consumer_read_valid | consumer_write_valid),
      .ptr         (rr_q),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   always_comb begin
      state_d             = state_q;
      ch_d                = ch_q;
      rr_d                = rr_q;
      mem_read_valid_d    = mem_read_valid_q;
      mem_write_valid_d   = mem_write_valid_q;
      mem_read_address_d  = mem_read_address_q;
      mem_write_address_d = mem_write_address_q;
      mem_write_data_d    = mem_write_data_q;
      read_ready_d        = read_ready_q;
      write_ready_d       = write_ready_q;
      read_data_d         = read_data_q;
      case (state_q)
         IDLE: if (grant_valid) begin
            ch_d = grant;
            // a channel presenting both kinds is served its write first
            if (consumer_write_valid[grant]) begin
               mem_write_valid_d   = 1'b1;
               mem_write_address_d = consumer_write_address[grant*ADDR_BITS +: ADDR_BITS];
               mem_write_data_d    = consumer_write_data[grant*DATA_BITS +: DATA_BITS];
               state_d             = WRITE_WAITING;
            end else begin
               mem_read_valid_d   = 1'b1;
               mem_read_address_d = consumer_read_address[grant*ADDR_BITS +: ADDR_BITS];
               state_d            = READ_WAITING;
            end
         end
         READ_WAITING: if (mem_read_ready) begin
            mem_read_valid_d                           = 1'b0;
            read_data_d[ch_q*DATA_BITS +: DATA_BITS]   = mem_read_data;
            read_ready_d[ch_q]                         = 1'b1;
            state_d                                    = READ_RELAYING;
         end
         WRITE_WAITING: if (mem_write_ready) begin
            mem_write_valid_d   = 1'b0;
            write_ready_d[ch_q] = 1'b1;
            state_d             = WRITE_RELAYING;
         end
         READ_RELAYING: if (!consumer_read_valid[ch_q]) begin
            read_ready_d[ch_q] = 1'b0;
            rr_d               = (int'(ch_q) == N - 1) ? '0 : ch_q + 1'b1;
            state_d            = IDLE;
         end
         WRITE_RELAYING: if (!consumer_write_valid[ch_q]) begin
            write_ready_d[ch_q] = 1'b0;
            rr_d                = (int'(ch_q) == N - 1) ? '0 : ch_q + 1'b1;
            state_d             = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q             <= IDLE;
         ch_q                <= '0;
         rr_q                <= '0;
         mem_read_valid_q    <= 1'b0;
         mem_write_valid_q   <= 1'b0;
         mem_read_address_q  <= '0;
         mem_write_address_q <= '0;
         mem_write_data_q    <= '0;
         read_ready_q        <= '0;
         write_ready_q       <= '0;
         read_data_q         <= '0;
      end else begin
         state_q             <= state_d;
         ch_q                <= ch_d;
         rr_q                <= rr_d;
         mem_read_valid_q    <= mem_read_valid_d;
         mem_write_valid_q   <= mem_write_valid_d;
         mem_read_address_q  <= mem_read_address_d;
         mem_write_address_q <= mem_write_address_d;
         mem_write_data_q    <= mem_write_data_d;
         read_ready_q        <= read_ready_d;
         write_ready_q       <= write_ready_d;
         read_data_q         <= read_data_d;
      end
   end

   assign consumer_read_ready  = read_ready_q;
   assign consumer_read_data   = read_data_q;
   assign consumer_write_ready = write_ready_q;
   assign mem_read_valid       = mem_read_valid_q;
   assign mem_read_address     = mem_read_address_q;
   assign mem_write_valid      = mem_write_valid_q;
   assign mem_write_address    = mem_write_address_q;
   assign mem_write_data       = mem_write_data_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random cache-channel traffic checked by a scoreboard against a shadow memory
module tb_dmem_responder;
   localparam int N = 4, A = 8, D = 8;

   logic           clk = 1'b0, reset = 1'b0;
   logic [N-1:0]   crv = '0, cwv = '0, crr, cwr;
   logic [N*A-1:0] cra = '0, cwa = '0;
   logic [N*D-1:0] cwd = '0, crd;
   logic           mrv, mwv, mrr = 1'b0, mwr = 1'b0;
   logic [A-1:0]   mra, mwa;
   logic [D-1:0]   mrd = '0, mwd;

   dmem_responder #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) dut (
      .clk(clk), .reset(reset),
      .consumer_read_valid(crv), .consumer_read_address(cra),
      .consumer_read_ready(crr), .consumer_read_data(crd),
      .consumer_write_valid(cwv), .consumer_write_address(cwa),
      .consumer_write_data(cwd), .consumer_write_ready(cwr),
      .mem_read_valid(mrv), .mem_read_address(mra),
      .mem_read_ready(mrr), .mem_read_data(mrd),
      .mem_write_valid(mwv), .mem_write_address(mwa),
      .mem_write_data(mwd), .mem_write_ready(mwr)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [1:0] kind; logic [A-1:0] ra; logic [A-1:0] wa; logic [D-1:0] wd; } cmd_t;
   typedef struct packed { logic wr; logic [A-1:0] a; logic [D-1:0] d; } txn_t;

   cmd_t         cmd_q[N][$];
   txn_t         exp_q[N][$];
   int           gnt_q[$];
   int           order_q[$];
   logic [D-1:0] mem[256];
   logic [D-1:0] shadow[256];
   logic [D-1:0] held[N];
   int           hold_r[N], hold_w[N];
   int           hold_max, lat, lat_cfg, rr_model;
   bit           eager, stall, spurious;
   logic         last_wr;
   logic [A-1:0] last_a;
   logic [D-1:0] last_d;
   logic [N-1:0] prev_crr = '0, prev_cwr = '0, req_seen = '0, wreq_seen = '0;
   logic         prev_mrv = 1'b0, prev_mwv = 1'b0;
   int           n_vec = 0, n_err = 0;

   // request vector the DUT saw at each edge, for predicting the grant
   always @(posedge clk) begin
      req_seen  <= crv | cwv;
      wreq_seen <= cwv;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      if ((mrv && !prev_mrv) || (mwv && !prev_mwv)) begin
         int g = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && req_seen[(rr_model + k) % N]) g = (rr_model + k) % N;
         chk("grant_kind", 32'(mwv), 32'((g >= 0) ? wreq_seen[g] : 1'b0));
         gnt_q.push_back(g);
      end
      for (int c = 0; c < N; c++) begin
         if ((crr[c] && !prev_crr[c]) || (cwr[c] && !prev_cwr[c])) begin
            int   g;
            txn_t t;
            chk("ready_onehot", 32'(crr | cwr), 32'(1 << c));
            g = (gnt_q.size() > 0) ? gnt_q.pop_front() : -1;
            chk("grant_ch", 32'(c), 32'(g));
            order_q.push_back(c);
            rr_model = (c + 1) % N;
            if (exp_q[c].size() == 0) chk("unexpected_ready", 32'(c), 32'hFFFF_FFFF);
            else begin
               t = exp_q[c].pop_front();
               chk("kind", 32'(cwr[c]), 32'(t.wr));
               chk("mem_kind", 32'(last_wr), 32'(t.wr));
               chk("mem_addr", 32'(last_a), 32'(t.a));
               if (t.wr) begin
                  chk("mem_wdata", 32'(last_d), 32'(t.d));
                  shadow[t.a] = t.d;
               end else begin
                  chk("rdata", 32'(crd[c*D +: D]), 32'(shadow[t.a]));
                  held[c] = shadow[t.a];
               end
            end
         end else chk("rdata_keep", 32'(crd[c*D +: D]), 32'(held[c]));
      end
      prev_crr = crr;
      prev_cwr = cwr;
      prev_mrv = mrv;
      prev_mwv = mwv;
   endtask

   task automatic memory();
      mrr = 1'b0;
      mwr = 1'b0;
      if (!reset) return;
      if (mrv || mwv) begin
         if (!stall) begin
            if (lat > 0) lat--;
            else begin
               if (mrv) begin
                  mrr = 1'b1; mrd = mem[mra];
                  last_wr = 1'b0; last_a = mra; last_d = mem[mra];
               end else begin
                  mwr = 1'b1; mem[mwa] = mwd;
                  last_wr = 1'b1; last_a = mwa; last_d = mwd;
               end
               lat = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
            end
         end
      end else if (spurious && $urandom_range(0, 7) == 0) begin
         if ($urandom_range(0, 1) == 1) begin
            mrr = 1'b1; mrd = 8'($urandom);
         end else mwr = 1'b1;
      end
   endtask

   task automatic consumers();
      for (int c = 0; c < N; c++) begin
         bit busy = crv[c] | cwv[c];
         if (cwv[c] && cwr[c]) begin
            if (hold_w[c] > 0) hold_w[c]--; else cwv[c] = 1'b0;
         end
         if (crv[c] && crr[c]) begin
            if (hold_r[c] > 0) hold_r[c]--; else crv[c] = 1'b0;
         end
         if (!busy && cmd_q[c].size() > 0 && (eager || $urandom_range(0, 3) == 0)) begin
            cmd_t m = cmd_q[c].pop_front();
            txn_t t;
            hold_r[c] = int'($urandom_range(0, hold_max));
            hold_w[c] = int'($urandom_range(0, hold_max));
            if (m.kind != 2'd0) begin
               cwv[c] = 1'b1; cwa[c*A +: A] = m.wa; cwd[c*D +: D] = m.wd;
               t = '{wr: 1'b1, a: m.wa, d: m.wd};
               exp_q[c].push_back(t);
            end
            if (m.kind != 2'd1) begin
               crv[c] = 1'b1; cra[c*A +: A] = m.ra;
               t = '{wr: 1'b0, a: m.ra, d: '0};
               exp_q[c].push_back(t);
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor();
      memory();
      consumers();
   endtask

   task automatic push(input int c, input int kind, input int ra, input int wa, input int wd);
      cmd_t m = '{kind: 2'(kind), ra: 8'(ra), wa: 8'(wa), wd: 8'(wd)};
      cmd_q[c].push_back(m);
   endtask

   task automatic drain(input int budget);
      int  n = 0;
      bit  busy = 1'b1;
      while (n < budget && busy) begin
         cycle();
         n++;
         busy = (crv != '0) || (cwv != '0) || (gnt_q.size() != 0);
         for (int c = 0; c < N; c++) busy |= (cmd_q[c].size() != 0) || (exp_q[c].size() != 0);
      end
      chk("drain_timeout", 32'(n >= budget), 32'd0);
      repeat (3) cycle();
   endtask

   task automatic check_all_zero();
      chk("rst_mrv", 32'(mrv), 0);
      chk("rst_mwv", 32'(mwv), 0);
      chk("rst_crr", 32'(crr), 0);
      chk("rst_cwr", 32'(cwr), 0);
      chk("rst_mra", 32'(mra), 0);
      chk("rst_mwa", 32'(mwa), 0);
      chk("rst_mwd", 32'(mwd), 0);
      chk("rst_crd", crd, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'(i * 7 + 3);
         shadow[i] = mem[i];
      end
      for (int c = 0; c < N; c++) begin
         held[c] = '0; hold_r[c] = 0; hold_w[c] = 0;
      end
      hold_max = 0; eager = 1'b1; lat_cfg = 1; lat = 1;
      stall = 1'b0; spurious = 1'b0; rr_model = 0;
      repeat (3) @(negedge clk);
      check_all_zero();
      reset = 1'b1;

      // all channels reading at once, dropping valid right after ready
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < N; c++) push(c, 0, $urandom_range(0, 255), 0, 0);
      drain(400);
      chk("rr_count", 32'(order_q.size()), 32'd12);
      for (int i = 0; i < order_q.size() && i < 12; i++) chk("rr_order", 32'(order_q[i]), 32'(i % N));

      mem[8'h2A] = 8'h5C; shadow[8'h2A] = 8'h5C;
      lat_cfg = 3; lat = 3;
      push(0, 0, 8'h2A, 0, 0);
      drain(100);
      chk("rd_ch0_data", 32'(crd[7:0]), 32'h5C);
      chk("rd_ch0_addr", 32'(last_a), 32'h2A);

      push(2, 1, 0, 8'h10, 8'h7F);
      drain(100);
      chk("wr_mem", 32'(mem[8'h10]), 32'h7F);
      chk("wr_ready_clear", 32'(cwr), 0);

      order_q.delete();
      push(1, 2, 8'h21, 8'h21, 8'h44);
      drain(100);
      chk("both_grants", 32'(order_q.size()), 32'd2);
      chk("both_rdata", 32'(crd[15:8]), 32'h44);

      hold_max = 2; eager = 1'b0; lat_cfg = -1; spurious = 1'b1;
      for (int i = 0; i < 150; i++)
         push($urandom_range(0, N - 1), $urandom_range(0, 2), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255));
      drain(20000);

      // reset while a read is stalled in memory
      spurious = 1'b0; stall = 1'b1; eager = 1'b1; hold_max = 0;
      push(3, 0, 8'h33, 0, 0);
      for (int i = 0; i < 50 && !mrv; i++) cycle();
      chk("rst_setup_mrv", 32'(mrv), 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_all_zero();
      crv = '0; cwv = '0;
      for (int c = 0; c < N; c++) begin
         exp_q[c].delete(); cmd_q[c].delete(); held[c] = '0;
      end
      gnt_q.delete();
      rr_model = 0; stall = 1'b0; lat_cfg = 1; lat = 1;
      repeat (2) cycle();
      reset = 1'b1;
      order_q.delete();
      push(3, 0, 8'h33, 0, 0);
      drain(100);
      chk("post_rst_grants", 32'(order_q.size()), 32'd1);
      chk("post_rst_rdata", 32'(crd[31:24]), 32'(shadow[8'h33]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
